// File: rtl/pe_vec_sequencer.sv
// Vector command sequencer for the 4-lane SIMD PE: streams operand reads, aligns lane opcodes with
// returning RAM data and schedules result writes after the ALU / summation latency.
module pe_vec_sequencer #(
    parameter int OPCODE_LEN = 4,
    parameter int DRAM_DEPTH = 256,
    parameter int LEN_W      = 9,
    parameter int RAM_LAT    = 1,
    parameter int ALU_LAT    = 1,
    parameter int SUM_LAT    = 3,
    localparam int ADDR_W    = $clog2(DRAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    // Handshake: a command transfers in the cycle where cmd_valid and cmd_ready are both 1;
    // cmd_ready is 1 only while idle and the source holds the command stable until then.
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [OPCODE_LEN-1:0] cmd_op,
    input  logic [ADDR_W-1:0]     cmd_a_base,
    input  logic [ADDR_W-1:0]     cmd_b_base,
    input  logic [ADDR_W-1:0]     cmd_res_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  abort,
    output logic                  ram_a_rd_en,
    output logic [ADDR_W-1:0]     ram_a_read_addr,
    output logic                  ram_b_rd_en,
    output logic [ADDR_W-1:0]     ram_b_read_addr,
    output logic [OPCODE_LEN-1:0] pe_opcode,
    output logic                  pe_acc_clr,
    output logic                  res_wr_en,
    output logic [ADDR_W-1:0]     res_wr_addr,
    output logic                  res_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            dbg_state
);

    localparam int WR_LAT = RAM_LAT + ALU_LAT;
    localparam int DP_LAT = WR_LAT + SUM_LAT;
    localparam int CNT_W  = $clog2(DP_LAT + 1);

    localparam logic [OPCODE_LEN-1:0] OP_NOOP = OPCODE_LEN'(0);
    localparam logic [OPCODE_LEN-1:0] OP_ADD  = OPCODE_LEN'(1);
    localparam logic [OPCODE_LEN-1:0] OP_SUB  = OPCODE_LEN'(2);
    localparam logic [OPCODE_LEN-1:0] OP_MUL  = OPCODE_LEN'(3);
    localparam logic [OPCODE_LEN-1:0] OP_DOTP = OPCODE_LEN'(4);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [OPCODE_LEN-1:0] op_q, op_d;
    logic [ADDR_W-1:0]     a_base_q, a_base_d;
    logic [ADDR_W-1:0]     b_base_q, b_base_d;
    logic [ADDR_W-1:0]     res_q, res_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  flush;

    // Per-word tokens travelling alongside the data: valid/index up to the lane write,
    // first-word flag up to the opcode tap, last-word (DOTP only) up to the scalar write.
    logic [WR_LAT-1:0]     dv_q;
    logic [RAM_LAT-1:0]    dfirst_q;
    logic [DP_LAT-1:0]     dlast_q;
    logic [ADDR_W-1:0]     didx_q [WR_LAT];

    logic issue, is_dotp, first_word, last_word, cmd_legal, ew_wr, dp_wr;

    assign issue      = (state_q == S_ISSUE);
    assign is_dotp    = (op_q == OP_DOTP);
    assign first_word = (idx_q == '0);
    assign last_word  = (idx_q == len_q - LEN_W'(1));
    assign cmd_legal  = (cmd_op == OP_ADD) || (cmd_op == OP_SUB) ||
                        (cmd_op == OP_MUL) || (cmd_op == OP_DOTP);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_base_d = a_base_q;
        b_base_d = b_base_q;
        res_d    = res_q;
        len_d    = len_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        flush    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d     = cmd_op;
                    a_base_d = cmd_a_base;
                    b_base_d = cmd_b_base;
                    res_d    = cmd_res_addr;
                    len_d    = cmd_len;
                    idx_d    = '0;
                    // Empty or illegal commands complete without touching the RAMs.
                    if (!cmd_legal || cmd_len == '0) begin
                        done_d = 1'b1;
                        err_d  = !cmd_legal;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    flush   = 1'b1;
                end else if (last_word) begin
                    state_d = S_DRAIN;
                    cnt_d   = is_dotp ? CNT_W'(DP_LAT - 1) : CNT_W'(WR_LAT - 1);
                end else begin
                    idx_d = idx_q + LEN_W'(1);
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    flush   = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_NOOP;
            a_base_q <= '0;
            b_base_q <= '0;
            res_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_base_q <= a_base_d;
            b_base_q <= b_base_d;
            res_q    <= res_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            dv_q     <= '0;
            dfirst_q <= '0;
            dlast_q  <= '0;
            for (int k = 0; k < WR_LAT; k++) didx_q[k] <= '0;
        end else begin
            dv_q[0]     <= issue;
            didx_q[0]   <= idx_q[ADDR_W-1:0];
            dfirst_q[0] <= issue & first_word;
            // Gated by DOTP so a lane command's token cannot reach the scalar tap after
            // the next command has been accepted.
            dlast_q[0]  <= issue & last_word & is_dotp;
            for (int k = 1; k < WR_LAT; k++) begin
                dv_q[k]   <= dv_q[k-1];
                didx_q[k] <= didx_q[k-1];
            end
            for (int k = 1; k < RAM_LAT; k++) dfirst_q[k] <= dfirst_q[k-1];
            for (int k = 1; k < DP_LAT; k++)  dlast_q[k]  <= dlast_q[k-1];
        end
    end

    assign ew_wr = dv_q[WR_LAT-1] & ~is_dotp;
    assign dp_wr = dlast_q[DP_LAT-1] & is_dotp;

    assign cmd_ready       = (state_q == S_IDLE);
    assign busy            = (state_q != S_IDLE);
    assign ram_a_rd_en     = issue;
    assign ram_b_rd_en     = issue;
    assign ram_a_read_addr = issue ? a_base_q + idx_q[ADDR_W-1:0] : '0;
    assign ram_b_read_addr = issue ? b_base_q + idx_q[ADDR_W-1:0] : '0;
    assign pe_opcode       = dv_q[RAM_LAT-1] ? op_q : OP_NOOP;
    assign pe_acc_clr      = dfirst_q[RAM_LAT-1] & is_dotp;
    assign res_wr_en       = ew_wr | dp_wr;
    assign res_sel         = dp_wr;
    assign res_wr_addr     = ew_wr ? res_q + didx_q[WR_LAT-1] : (dp_wr ? res_q : '0);
    assign done            = done_q;
    assign err             = err_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_pe_vec_sequencer.sv
// Bench for pe_vec_sequencer: a cycle-stamped scoreboard of reads, lane opcodes, writes and
// completions is filled from the command timing rules and drained by a negedge monitor.
module tb_pe_vec_sequencer;

    localparam int RAM_LAT = 1;
    localparam int ALU_LAT = 1;
    localparam int SUM_LAT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a_base, cmd_b_base, cmd_res_addr;
    logic [8:0] cmd_len;
    logic       abort;
    logic       ram_a_rd_en, ram_b_rd_en;
    logic [7:0] ram_a_read_addr, ram_b_read_addr;
    logic [3:0] pe_opcode;
    logic       pe_acc_clr;
    logic       res_wr_en;
    logic [7:0] res_wr_addr;
    logic       res_sel;
    logic       busy, done, err;
    logic [1:0] dbg_state;

    pe_vec_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a_base(cmd_a_base), .cmd_b_base(cmd_b_base), .cmd_res_addr(cmd_res_addr),
        .cmd_len(cmd_len), .abort(abort),
        .ram_a_rd_en(ram_a_rd_en), .ram_a_read_addr(ram_a_read_addr),
        .ram_b_rd_en(ram_b_rd_en), .ram_b_read_addr(ram_b_read_addr),
        .pe_opcode(pe_opcode), .pe_acc_clr(pe_acc_clr),
        .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_sel(res_sel),
        .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int n_chk = 0;
    int n_err = 0;
    int t0_cyc = 0;
    bit done_seen = 1'b0;

    // expected queues, each entry {cycle relative to t0, payload}
    logic [33:0] exp_rd_q[$];  // {cyc, a_en, b_en, a_addr, b_addr}
    logic [20:0] exp_op_q[$];  // {cyc, acc_clr, opcode}
    logic [24:0] exp_wr_q[$];  // {cyc, res_sel, addr}
    logic [16:0] exp_dn_q[$];  // {cyc, err}

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc_cnt);
        end
    endtask

    // monitor
    logic [15:0] rel;
    always @(negedge clk) begin
        rel = 16'(cyc_cnt - t0_cyc);
        if (ram_a_rd_en || ram_b_rd_en) begin
            check("rd_avail", 64'(exp_rd_q.size() != 0), 64'(1));
            if (exp_rd_q.size() != 0)
                check("rd", 64'({rel, ram_a_rd_en, ram_b_rd_en, ram_a_read_addr, ram_b_read_addr}),
                      64'(exp_rd_q.pop_front()));
        end
        if (pe_opcode != 4'd0 || pe_acc_clr) begin
            check("op_avail", 64'(exp_op_q.size() != 0), 64'(1));
            if (exp_op_q.size() != 0)
                check("op", 64'({rel, pe_acc_clr, pe_opcode}), 64'(exp_op_q.pop_front()));
        end
        if (res_wr_en) begin
            check("wr_avail", 64'(exp_wr_q.size() != 0), 64'(1));
            if (exp_wr_q.size() != 0)
                check("wr", 64'({rel, res_sel, res_wr_addr}), 64'(exp_wr_q.pop_front()));
        end
        if (done) begin
            done_seen = 1'b1;
            check("done_avail", 64'(exp_dn_q.size() != 0), 64'(1));
            if (exp_dn_q.size() != 0)
                check("done", 64'({rel, err}), 64'(exp_dn_q.pop_front()));
            check("done_idle", 64'({cmd_ready, busy}), 64'(2'b10));
        end
    end

    // driver tasks; all of them start and end 1 time unit after a rising edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_queues();
        exp_rd_q.delete();
        exp_op_q.delete();
        exp_wr_q.delete();
        exp_dn_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 64'({ram_a_rd_en, ram_a_read_addr, ram_b_rd_en, ram_b_read_addr, pe_opcode,
                        pe_acc_clr, res_wr_en, res_wr_addr, res_sel, busy, done, err, dbg_state}),
              64'(0));
        check({tag, "_ready"}, 64'(cmd_ready), 64'(1));
    endtask

    task automatic send_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] r, input logic [8:0] len, input bit abort_t0);
        bit legal, dotp, normal;
        legal  = (op >= 4'd1) && (op <= 4'd4);
        dotp   = (op == 4'd4);
        normal = legal && (len != 9'd0);
        done_seen    = 1'b0;
        cmd_op       = op;
        cmd_a_base   = a;
        cmd_b_base   = b;
        cmd_res_addr = r;
        cmd_len      = len;
        cmd_valid    = 1'b1;
        abort        = abort_t0;
        t0_cyc       = cyc_cnt;
        check("ready_t0", 64'(cmd_ready), 64'(1));
        if (!normal) begin
            exp_dn_q.push_back({16'd1, !legal});
        end else begin
            for (int i = 0; i < int'(len); i++) begin
                exp_rd_q.push_back({16'(1 + i), 2'b11, 8'(int'(a) + i), 8'(int'(b) + i)});
                exp_op_q.push_back({16'(1 + i + RAM_LAT), dotp && (i == 0), op});
                if (!dotp)
                    exp_wr_q.push_back({16'(1 + i + RAM_LAT + ALU_LAT), 1'b0, 8'(int'(r) + i)});
            end
            if (dotp) begin
                exp_wr_q.push_back({16'(int'(len) + RAM_LAT + ALU_LAT + SUM_LAT), 1'b1, r});
                exp_dn_q.push_back({16'(int'(len) + RAM_LAT + ALU_LAT + SUM_LAT + 1), 1'b0});
            end else begin
                exp_dn_q.push_back({16'(int'(len) + RAM_LAT + ALU_LAT + 1), 1'b0});
            end
        end
        step(1);
        cmd_valid = 1'b0;
        abort     = 1'b0;
        cmd_op    = 4'd0;
        check("state_t1", 64'({busy, cmd_ready}), normal ? 64'(2'b10) : 64'(2'b01));
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done_seen && n < budget) begin
            step(1);
            n++;
        end
        if (!done_seen) step(1);
        check({tag, "_done_seen"}, 64'(done_seen), 64'(1));
        check({tag, "_q_empty"},
              64'(exp_rd_q.size() + exp_op_q.size() + exp_wr_q.size() + exp_dn_q.size()), 64'(0));
        clear_queues();
    endtask

    // keep only events at or before cycle ta; the completion never comes
    task automatic prune(input int ta);
        logic [33:0] rd_k[$];
        logic [20:0] op_k[$];
        logic [24:0] wr_k[$];
        foreach (exp_rd_q[i]) if (int'(exp_rd_q[i][33:18]) <= ta) rd_k.push_back(exp_rd_q[i]);
        foreach (exp_op_q[i]) if (int'(exp_op_q[i][20:5]) <= ta) op_k.push_back(exp_op_q[i]);
        foreach (exp_wr_q[i]) if (int'(exp_wr_q[i][24:9]) <= ta) wr_k.push_back(exp_wr_q[i]);
        exp_rd_q = rd_k;
        exp_op_q = op_k;
        exp_wr_q = wr_k;
        exp_dn_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a_base = 8'd0; cmd_b_base = 8'd0;
        cmd_res_addr = 8'd0; cmd_len = 9'd0; abort = 1'b0;
        #2;
        check_reset_outputs("reset");
        step(3);
        rst = 1'b0;
        step(2);
        check_reset_outputs("post_reset");

        // directed commands
        send_cmd(4'd1, 8'h10, 8'h20, 8'h30, 9'd4, 1'b0); wait_done("add4", 20);
        send_cmd(4'd4, 8'h00, 8'h80, 8'h40, 9'd4, 1'b0); wait_done("dotp4", 20);
        send_cmd(4'd3, 8'hFE, 8'h05, 8'hFF, 9'd3, 1'b0); wait_done("mul_wrap", 20);
        send_cmd(4'd1, 8'h11, 8'h22, 8'h33, 9'd0, 1'b0); wait_done("len0", 10);
        send_cmd(4'd7, 8'h11, 8'h22, 8'h33, 9'd5, 1'b0); wait_done("op7", 10);
        send_cmd(4'd0, 8'h01, 8'h02, 8'h03, 9'd2, 1'b0); wait_done("op0", 10);
        send_cmd(4'd2, 8'h7F, 8'h80, 8'h81, 9'd1, 1'b0); wait_done("sub1", 20);
        send_cmd(4'd4, 8'hFF, 8'h00, 8'hAA, 9'd1, 1'b0); wait_done("dotp1", 20);
        send_cmd(4'd2, 8'h05, 8'h06, 8'h07, 9'd3, 1'b1); wait_done("abort_idle", 20);

        // abort at t3 of ADD len=8
        send_cmd(4'd1, 8'h00, 8'h40, 8'h80, 9'd8, 1'b0);
        step(2);
        abort = 1'b1;
        prune(3);
        step(1);
        abort = 1'b0;
        check("abort_t4", 64'({cmd_ready, busy}), 64'(2'b10));
        step(12);
        check("abort_no_done", 64'(done_seen), 64'(0));
        check("abort_q_empty", 64'(exp_rd_q.size() + exp_op_q.size() + exp_wr_q.size()), 64'(0));
        clear_queues();
        send_cmd(4'd2, 8'h50, 8'h60, 8'h70, 9'd2, 1'b0); wait_done("after_abort", 20);

        // random back-to-back commands
        for (int n = 0; n < 8; n++) begin
            logic [3:0] rop;
            logic [8:0] rlen;
            rop  = 4'($urandom_range(1, 4));
            rlen = 9'($urandom_range(1, 12));
            send_cmd(rop, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)), rlen, 1'b0);
            wait_done("rand", 40);
        end

        // full-depth command wrapping the whole RAM
        send_cmd(4'd1, 8'h80, 8'hC0, 8'h01, 9'd256, 1'b0); wait_done("add256", 300);

        // reset at t5 of DOTP len=16
        send_cmd(4'd4, 8'h10, 8'h20, 8'h50, 9'd16, 1'b0);
        step(4);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        clear_queues();
        step(2);
        rst = 1'b0;
        step(25);
        check("rst_no_done", 64'(done_seen), 64'(0));
        send_cmd(4'd3, 8'h01, 8'h02, 8'h03, 9'd2, 1'b0); wait_done("after_rst", 20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
